// File: rtl/range_pkg.sv
// Shared types and constants for the range finder and its self-test sequencer.
package range_pkg;

  // Default sample/range width, shared with the range finder.
  localparam int RANGE_WIDTH = 10;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    CAPTURE,
    REPORT
  } seq_state_t;

endpackage

// File: rtl/sample_buffer.sv
// Append-only sample store. It has a fill count, full detection, a clear
// input and an asynchronous read port.
module sample_buffer #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_write;

  assign full     = (count == CW'(DEPTH));
  assign do_write = wr_en && !full && !clear;
  assign rd_data  = mem[rd_idx];

  // Fill count: clear empties the buffer, and each accepted write appends one sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (do_write) begin
      count <= count + CW'(1);
    end
  end

  // Sample storage.
  // NOTE: the array has no reset. Contents beyond count are never read, so resetting it only adds reset fan-out.
  always_ff @(posedge clock) begin
    if (do_write) begin
      mem[count[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/range_sequencer.sv
// On-chip self-test driver for the range finder. It plays a stored sample
// sequence, captures the finder's answer and compares it with its own
// max - min.
module range_sequencer
  import range_pkg::*;
#(
  parameter int WIDTH = RANGE_WIDTH,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       load_valid,
  input  logic [WIDTH-1:0]           load_data,
  output logic                       load_ready,
  input  logic                       clear,
  input  logic                       start,
  output logic                       busy,
  output logic [WIDTH-1:0]           data_out,
  output logic                       go,
  output logic                       finish,
  input  logic [WIDTH-1:0]           range_in,
  input  logic                       error_in,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           expected,
  output logic [WIDTH-1:0]           result,
  output logic                       done,
  output logic                       pass
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  seq_state_t       state, state_next;
  logic [CW-1:0]    idx;        // index of the next sample to present
  logic [WIDTH-1:0] max_q, min_q;
  logic [WIDTH-1:0] span;
  logic [WIDTH-1:0] rd_data;
  logic [AW-1:0]    rd_idx;
  logic             err_q;
  logic             full;
  logic             is_idle;
  logic             start_go;

  assign is_idle    = (state == IDLE);
  assign start_go   = is_idle && start && (count != '0);
  assign load_ready = is_idle && !full;
  assign busy       = !is_idle;
  assign rd_idx     = is_idle ? '0 : idx[AW-1:0];
  assign span       = max_q - min_q;

  sample_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW),
    .AW    (AW)
  ) u_buffer (
    .clock   (clock),
    .reset   (reset),
    .clear   (is_idle && clear && !start_go),
    .wr_en   (is_idle && load_valid && !start_go),
    .wr_data (load_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .count   (count),
    .full    (full)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // NOTE: the default assignment comes first so that every path assigns state_next and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_go) state_next = PLAY;
      PLAY:    if (finish)   state_next = CAPTURE;
      CAPTURE: state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Playback outputs, max/min tracking, capture, error flag and report.
  // NOTE: all state in this block uses non-blocking assignments. Every register then sees pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      go       <= 1'b0;
      finish   <= 1'b0;
      idx      <= '0;
      max_q    <= '0;
      min_q    <= '0;
      err_q    <= 1'b0;
      result   <= '0;
      expected <= '0;
      pass     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_go) begin
            data_out <= rd_data;
            go       <= 1'b1;
            finish   <= (count == CW'(1));
            idx      <= CW'(1);
            max_q    <= rd_data;
            min_q    <= rd_data;
            err_q    <= 1'b0;
            pass     <= 1'b0;
          end
        end
        PLAY: begin
          if (error_in) err_q <= 1'b1;
          if (finish) begin
            data_out <= '0;
            go       <= 1'b0;
            finish   <= 1'b0;
          end else begin
            data_out <= rd_data;
            go       <= 1'b0;
            finish   <= (idx == count - CW'(1));
            idx      <= idx + CW'(1);
            if (rd_data > max_q) max_q <= rd_data;
            if (rd_data < min_q) min_q <= rd_data;
          end
        end
        CAPTURE: begin
          result   <= range_in;
          expected <= span;
          err_q    <= err_q | error_in;
          pass     <= (range_in == span) && !err_q && !error_in;
          done     <= 1'b1;
        end
        REPORT: begin
          done <= 1'b0;
          idx  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_range_sequencer.sv
// Self-checking bench for range_sequencer. A queue-based model supplies the
// expected playback order and the max - min result.
module tb_range_sequencer;
  import range_pkg::*;

  localparam int WIDTH = 10;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic             load_ready;
  logic             clear = 1'b0;
  logic             start = 1'b0;
  logic             busy;
  logic [WIDTH-1:0] data_out;
  logic             go, finish;
  logic [WIDTH-1:0] range_in = '0;
  logic             error_in = 1'b0;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] expected, result;
  logic             done, pass;

  int errors = 0;
  int checks = 0;
  int model_q[$];
  bit model_pass = 1'b0;

  range_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .clear(clear), .start(start), .busy(busy),
    .data_out(data_out), .go(go), .finish(finish), .range_in(range_in),
    .error_in(error_in), .count(count), .expected(expected), .result(result),
    .done(done), .pass(pass)
  );

  always #5 clock = ~clock;

  // Advance one cycle. Outputs are read, and inputs driven, 1 ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Range of the stored sequence, computed from the model queue.
  function automatic int model_range();
    int mx, mn;
    mx = model_q[0];
    mn = model_q[0];
    foreach (model_q[k]) begin
      if (model_q[k] > mx) mx = model_q[k];
      if (model_q[k] < mn) mn = model_q[k];
    end
    return mx - mn;
  endfunction

  task automatic load_sample(input int v);
    load_valid = 1'b1;
    load_data  = WIDTH'(v);
    step();
    load_valid = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(v);
    checks++;
    if (count !== CW'(model_q.size())) begin
      errors++;
      $display("FAIL load_count: got %0d want %0d", count, model_q.size());
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_q.delete();
    checks++;
    if (count !== '0) begin
      errors++;
      $display("FAIL clear_count: got %0d want 0", count);
    end
  endtask

  // Play the stored sequence. err_k selects the PLAY cycle (0..n-1) or the
  // CAPTURE cycle (n) in which error_in is raised; a negative value means no
  // error. With noise set, start/clear/load are raised during PLAY.
  task automatic run_seq(input int rng, input int err_k, input bit noise);
    int n, exp_r;
    logic [WIDTH+5:0] got_v, exp_v;
    n     = model_q.size();
    exp_r = model_range();
    model_pass = (rng == exp_r) && (err_k < 0);
    start = 1'b1;
    step();
    start    = 1'b0;
    range_in = WIDTH'(rng);
    for (int k = 0; k < n; k++) begin
      got_v = {busy, go, finish, pass, done, count == CW'(n), data_out};
      exp_v = {1'b1, k == 0, k == n - 1, 1'b0, 1'b0, 1'b1, WIDTH'(model_q[k])};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL play[%0d] {busy,go,finish,pass,done,count_ok,data}: got %h want %h",
                 k, got_v, exp_v);
      end
      error_in = (k == err_k);
      if (noise) begin
        start      = 1'b1;
        clear      = 1'b1;
        load_valid = 1'b1;
        load_data  = WIDTH'($urandom_range(0, 1023));
      end
      step();
    end
    start      = 1'b0;
    clear      = 1'b0;
    load_valid = 1'b0;
    error_in   = (err_k == n);
    checks++;
    if ({busy, go, finish, done, data_out} !== {1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(0)}) begin
      errors++;
      $display("FAIL capture_cycle {busy,go,finish,done,data}: got %b%b%b%b %0d want 1000 0",
               busy, go, finish, done, data_out);
    end
    step();
    error_in = 1'b0;
    checks++;
    if ({busy, done} !== 2'b11) begin
      errors++;
      $display("FAIL report_done {busy,done}: got %b%b want 11", busy, done);
    end
    checks++;
    if (expected !== WIDTH'(exp_r)) begin
      errors++;
      $display("FAIL report_expected: got %0d want %0d", expected, exp_r);
    end
    checks++;
    if (result !== WIDTH'(rng)) begin
      errors++;
      $display("FAIL report_result: got %0d want %0d", result, rng);
    end
    checks++;
    if (pass !== model_pass) begin
      errors++;
      $display("FAIL report_pass: got %b want %b", pass, model_pass);
    end
    step();
    checks++;
    if ({busy, done, pass, count} !== {1'b0, 1'b0, model_pass, CW'(n)}) begin
      errors++;
      $display("FAIL after_report {busy,done,pass,count}: got %b%b%b %0d want 00%b %0d",
               busy, done, pass, count, model_pass, n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({count, expected, result, pass, done, go, finish, data_out, busy, load_ready} !==
        {CW'(0), WIDTH'(0), WIDTH'(0), 1'b0, 1'b0, 1'b0, 1'b0, WIDTH'(0), 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: count=%0d exp=%0d res=%0d pass=%b done=%b go=%b fin=%b data=%0d busy=%b ready=%b",
               count, expected, result, pass, done, go, finish, data_out, busy, load_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    step();
    checks++;
    if ({busy, load_ready, count} !== {1'b0, 1'b1, CW'(0)}) begin
      errors++;
      $display("FAIL post_reset {busy,ready,count}: got %b%b %0d want 01 0", busy, load_ready, count);
    end
  endtask

  task automatic test_normal();
    do_clear();
    load_sample(5); load_sample(200); load_sample(37); load_sample(1023); load_sample(12);
    run_seq(1018, -1, 1'b0);
  endtask

  task automatic test_mismatch_and_error();
    run_seq(1000, -1, 1'b0);
    run_seq(1018, 2, 1'b0);
    run_seq(1018, 5, 1'b0);   // error raised in the CAPTURE cycle
    run_seq(1018, -1, 1'b0);  // error flag cleared by the new start
  endtask

  task automatic test_ignored_inputs();
    run_seq(1018, -1, 1'b1);
  endtask

  task automatic test_single();
    do_clear();
    load_sample(42);
    run_seq(0, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int n, mode, rng;
      do_clear();
      n = $urandom_range(1, DEPTH);
      for (int j = 0; j < n; j++) load_sample($urandom_range(0, 1023));
      mode = $urandom_range(0, 2);
      rng  = (mode == 1) ? $urandom_range(0, 1023) : model_range();
      run_seq(rng, (mode == 2) ? $urandom_range(0, n) : -1, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    load_sample(300); load_sample(7); load_sample(512);
    run_seq(505, -1, 1'b0);
    run_seq(505, -1, 1'b0);
  endtask

  task automatic test_boundaries();
    do_clear();
    for (int j = 0; j < DEPTH + 1; j++) load_sample(j * 37 + 1);
    checks++;
    if ({count, load_ready} !== {CW'(DEPTH), 1'b0}) begin
      errors++;
      $display("FAIL full {count,ready}: got %0d %b want %0d 0", count, load_ready, DEPTH);
    end
    run_seq(model_range(), -1, 1'b0);  // the 17th value must not be played
    clear      = 1'b1;
    load_valid = 1'b1;
    load_data  = 10'd7;
    step();
    clear      = 1'b0;
    load_valid = 1'b0;
    model_q.delete();
    checks++;
    if (count !== '0) begin
      errors++;
      $display("FAIL clear_vs_load: got %0d want 0", count);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL empty_start[%0d] {busy,done}: got %b%b want 00", j, busy, done);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_run();
    do_clear();
    load_sample(11); load_sample(22); load_sample(33); load_sample(44); load_sample(55);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();   // now presenting index 2
    checks++;
    if (data_out !== 10'd33) begin
      errors++;
      $display("FAIL mid_run_data: got %0d want 33", data_out);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({go, finish, busy, count, data_out} !== {1'b0, 1'b0, 1'b0, CW'(0), WIDTH'(0)}) begin
      errors++;
      $display("FAIL reset_mid_run {go,fin,busy,count,data}: got %b%b%b %0d %0d want 000 0 0",
               go, finish, busy, count, data_out);
    end
    #2;
    reset = 1'b1;
    model_q.delete();
    for (int j = 0; j < 6; j++) begin
      step();
      checks++;
      if ({done, busy} !== 2'b00) begin
        errors++;
        $display("FAIL post_abort[%0d] {done,busy}: got %b%b want 00", j, done, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_mismatch_and_error();
    test_ignored_inputs();
    test_single();
    test_back_to_back();
    test_random();
    test_boundaries();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/range_sequencer.md
# range_sequencer

Stimulus-side partner of the range finder. Holds a short programmed sequence of samples and plays it onto the finder's `data_in`/`go`/`finish` inputs one sample per cycle. It then captures the returned `range`/`debug_error` and reports pass/fail against the range it computes itself. It sits on the chip beside the range finder and serves as the on-chip self-test driver.

## Interface
- `WIDTH`, 10, sample and range width in bits
- `DEPTH`, 16, maximum samples in one sequence

- `clock`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `load_valid`  in  1  write `load_data` into the buffer this cycle
- `load_data`  in  WIDTH  sample to append
- `load_ready`  out  1  high when a load is accepted (IDLE and not full)
- `clear`  in  1  empty the buffer (IDLE only)
- `start`  in  1  begin playback (IDLE only)
- `busy`  out  1  high in any state other than IDLE
- `data_out`  out  WIDTH  drives finder `data_in`
- `go`  out  1  drives finder `go`
- `finish`  out  1  drives finder `finish`
- `range_in`  in  WIDTH  finder `range`
- `error_in`  in  1  finder `debug_error`
- `count`  out  clog2(DEPTH+1)  samples currently stored
- `expected`  out  WIDTH  max − min of the last played sequence
- `result`  out  WIDTH  captured `range_in`
- `done`  out  1  one-cycle pulse when the report is valid
- `pass`  out  1  (`result` == `expected`) and no error seen; held until the next start

## Operation
- The FSM has four states: IDLE, PLAY, CAPTURE and REPORT.
- **IDLE**
  - `clear` sets `count` to 0. `clear` wins over a simultaneous `load_valid`.
  - A load is accepted when `load_valid` is high and `load_ready` is high. The sample is written at index `count`, and `count` increments.
  - A load while full is dropped, and `count` is unchanged.
  - `start` with `count` ≥ 1 moves to PLAY and resets the index `i` to 0.
  - `start` with `count` = 0 is ignored, and no `done` is pulsed.
  - `start` takes priority over a same-cycle load. That load is dropped.
- **PLAY**
  - `data_out` = buf[i].
  - `go` = (i == 0).
  - `finish` = (i == count−1).
  - `count` = 1 drives `go` and `finish` in the same cycle.
  - Running max/min are updated from buf[i], with unsigned compare. They are seeded from buf[0].
  - After the cycle with `finish` high, move to CAPTURE.
- **CAPTURE**
  - `result` ← `range_in`.
  - `expected` ← max − min, unsigned WIDTH bits. It never wraps, since max ≥ min.
  - Move to REPORT.
- **REPORT**
  - `done` = 1 for this cycle only.
  - `pass` is updated.
  - Return to IDLE.
- **Error flag:** `error_in` high in any PLAY or CAPTURE cycle sets a sticky internal error flag. The flag forces `pass` = 0 and is cleared on `start`.
- **Outputs outside PLAY:** `data_out`, `go` and `finish` are 0.
- **Ignored inputs outside IDLE:** `start`, `clear` and `load_valid` are ignored.
- **Buffer retention:** the buffer and `count` are retained after REPORT, so the same sequence can be replayed with another `start`.

## Timing
- **Reset** (asynchronous, `reset` low):
  - State goes to IDLE.
  - `count`, `expected`, `result`, `pass`, `done`, `go`, `finish` and `data_out` go to 0.
  - `load_ready` is 1 after reset.
  - Buffer contents are don't-care.
- **Reset mid-sequence:** `go` and `finish` drop immediately and no `done` is issued.
- **Playback schedule:** for `start` sampled high in cycle t:
  - `go` and buf[0] appear in t+1.
  - buf[k] appears in t+1+k.
  - `finish` appears in t+count.
- **Capture and report:** `range_in` is sampled in t+count+1, the cycle after `finish`. `done` and valid `pass` appear in t+count+2.
- **Busy:** `busy` is high from t+1 through t+count+2 inclusive.
- **Back-to-back runs:** a `start` in the cycle after REPORT begins a new run.
- **Registered outputs:** all outputs are registered except `load_ready` and `busy`. Those two are combinational from state and `count`.

## Structure
- Package `range_pkg` holds:
  - the `seq_state_t` enum (IDLE, PLAY, CAPTURE, REPORT);
  - the default `WIDTH` constant, shared with the range finder.
- Sub-module `sample_buffer`:
  - DEPTH × WIDTH register array with a write pointer/`count`, full detection and clear;
  - asynchronous read port indexed by the sequencer's `i`.
- The top level holds the FSM, index, max/min trackers, capture registers and error flag.

## Test plan
- **Normal sequence:** load 5, 200, 37, 1023, 12, start.
  - Required: `go` with 5 in t+1, `finish` with 12 in t+5, `expected` = 1018.
  - Feed `range_in` = 1018 and `error_in` = 0 → `done` in t+7 with `pass` = 1.
- **Single sample:** load 42, start.
  - Required: `go` and `finish` both high in t+1, `expected` = 0.
  - Feed `range_in` = 0 → `pass` = 1.
- **Mismatch and error:** replay the first sequence without reloading.
  - Feed `range_in` = 1000 → `pass` = 0, `result` = 1000.
  - On another replay, assert `error_in` in PLAY with `range_in` = 1018 → `pass` = 0.
- **Buffer boundaries:**
  - Load 17 values with DEPTH = 16 → `count` = 16, `load_ready` = 0, 17th dropped.
  - `clear` together with `load_valid` → `count` = 0.
  - `start` with `count` = 0 → no `busy`, no `done`.
- **Ignored inputs:** `start`, `clear` and loads issued during PLAY are ignored; `count` is unchanged and the sequence is unperturbed.
- **Reset mid-run:** pull `reset` low at i = 2 → `go`, `finish`, `busy` and `count` read 0 immediately and no `done` follows.
